// File: rtl/rtc_bus_cycle.sv
// rtc_bus_cycle: one multiplexed-AD bus cycle to an RTC chip
// (address strobe, hold, gap, data strobe, hold, done pulse).
// Ports:
//   clk, rst        clock (rising) / async active-high reset
//   start           request a cycle; sampled only while idle
//   wr_rd           1 = write, 0 = read
//   addr, wdata     register address / write data
//   ad_in           AD pad value, captured on reads
//   ad_out, ad_oe   AD value to drive / drive enable
//   cs_n            chip select, active-low
//   ad_sel          0 = address phase, 1 = data phase
//   wr_n, rd_n      write / read strobes, active-low
//   rdata           data captured by the last read
//   busy, done      transaction in flight / end pulse
module rtc_bus_cycle #(
    parameter int unsigned T_STROBE = 4,
    parameter int unsigned T_HOLD   = 2,
    parameter int unsigned T_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       wr_rd,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_sel,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        A_STB,
        A_HLD,
        GAP,
        D_STB,
        D_HLD,
        FIN
    } state_t;

    typedef struct packed {
        logic       cs_n;
        logic       wr_n;
        logic       rd_n;
        logic       ad_sel;
        logic       ad_oe;
        logic [7:0] ad_out;
        logic       busy;
        logic       done;
    } bus_t;

    localparam logic [7:0] LD_STB = 8'(T_STROBE - 1);
    localparam logic [7:0] LD_HLD = 8'(T_HOLD - 1);
    localparam logic [7:0] LD_GAP = 8'(T_GAP - 1);

    localparam bus_t BUS_IDLE = '{
        cs_n:   1'b1,
        wr_n:   1'b1,
        rd_n:   1'b1,
        ad_sel: 1'b0,
        ad_oe:  1'b0,
        ad_out: 8'h00,
        busy:   1'b0,
        done:   1'b0
    };

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       wr_q;
    logic       wr_nx;
    logic [7:0] addr_q;
    logic [7:0] addr_nx;
    logic [7:0] data_q;
    logic [7:0] data_nx;
    logic       last;
    logic       cap;
    bus_t       bus;

    // Bus pin values for a given state. Outputs are registered from
    // the next state, so pins change on the same edge as the state.
    function automatic bus_t drive(
        input state_t     s,
        input logic       wr,
        input logic [7:0] a,
        input logic [7:0] d
    );
        bus_t b;
        b      = BUS_IDLE;
        b.busy = 1'b1;
        unique case (s)
            IDLE: begin
                b.busy = 1'b0;
            end
            A_STB: begin
                b.cs_n   = 1'b0;
                b.wr_n   = 1'b0;
                b.ad_oe  = 1'b1;
                b.ad_out = a;
            end
            A_HLD: begin
                b.ad_oe  = 1'b1;
                b.ad_out = a;
            end
            GAP: begin
                b.ad_oe  = 1'b0;
            end
            D_STB: begin
                b.cs_n   = 1'b0;
                b.ad_sel = 1'b1;
                if (wr) begin
                    b.wr_n   = 1'b0;
                    b.ad_oe  = 1'b1;
                    b.ad_out = d;
                end else begin
                    b.rd_n   = 1'b0;
                end
            end
            D_HLD: begin
                b.ad_sel = 1'b1;
                if (wr) begin
                    b.ad_oe  = 1'b1;
                    b.ad_out = d;
                end
            end
            FIN: begin
                b.done = 1'b1;
            end
            default: begin
                b.busy = 1'b0;
            end
        endcase
        return b;
    endfunction

    assign last = (cnt == 8'd0);

    // Next-state logic. Every timed state is left on the edge where
    // the shared down-counter reads zero; the counter is reloaded
    // with (length-1) for the state being entered.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        wr_nx    = wr_q;
        addr_nx  = addr_q;
        data_nx  = data_q;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = A_STB;
                    cnt_nx   = LD_STB;
                    wr_nx    = wr_rd;
                    addr_nx  = addr;
                    data_nx  = wdata;
                end
            end
            A_STB: begin
                if (last) begin
                    state_nx = A_HLD;
                    cnt_nx   = LD_HLD;
                end else begin
                    cnt_nx   = cnt - 8'd1;
                end
            end
            A_HLD: begin
                if (last) begin
                    state_nx = GAP;
                    cnt_nx   = LD_GAP;
                end else begin
                    cnt_nx   = cnt - 8'd1;
                end
            end
            GAP: begin
                if (last) begin
                    state_nx = D_STB;
                    cnt_nx   = LD_STB;
                end else begin
                    cnt_nx   = cnt - 8'd1;
                end
            end
            D_STB: begin
                if (last) begin
                    state_nx = D_HLD;
                    cnt_nx   = LD_HLD;
                    cap      = ~wr_q;
                end else begin
                    cnt_nx   = cnt - 8'd1;
                end
            end
            D_HLD: begin
                if (last) begin
                    state_nx = FIN;
                    cnt_nx   = 8'd0;
                end else begin
                    cnt_nx   = cnt - 8'd1;
                end
            end
            FIN: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            wr_q   <= 1'b0;
            addr_q <= 8'h00;
            data_q <= 8'h00;
            rdata  <= 8'h00;
            bus    <= BUS_IDLE;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            wr_q   <= wr_nx;
            addr_q <= addr_nx;
            data_q <= data_nx;
            if (cap) begin
                rdata <= ad_in;
            end
            bus    <= drive(state_nx, wr_nx, addr_nx, data_nx);
        end
    end

    assign cs_n   = bus.cs_n;
    assign wr_n   = bus.wr_n;
    assign rd_n   = bus.rd_n;
    assign ad_sel = bus.ad_sel;
    assign ad_oe  = bus.ad_oe;
    assign ad_out = bus.ad_out;
    assign busy   = bus.busy;
    assign done   = bus.done;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb_rtc_bus_cycle: directed bench for rtc_bus_cycle, default
// timing instance plus a 1/1/1 timing instance.
module tb_rtc_bus_cycle;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic       wr_rd = 1'b0;
    logic [7:0] addr  = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] ad_in = 8'h00;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       ad_sel;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] rdata;
    logic       busy;
    logic       done;

    logic       f_start = 1'b0;
    logic       f_wr_rd = 1'b0;
    logic [7:0] f_addr  = 8'h00;
    logic [7:0] f_wdata = 8'h00;
    logic [7:0] f_ad_in = 8'h00;
    logic [7:0] f_ad_out;
    logic       f_ad_oe;
    logic       f_cs_n;
    logic       f_ad_sel;
    logic       f_wr_n;
    logic       f_rd_n;
    logic [7:0] f_rdata;
    logic       f_busy;
    logic       f_done;

    int         n_run  = 0;
    int         n_fail = 0;
    logic [7:0] m_rdata = 8'h00;

    always #5 clk = ~clk;

    rtc_bus_cycle dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .wr_rd  (wr_rd),
        .addr   (addr),
        .wdata  (wdata),
        .ad_in  (ad_in),
        .ad_out (ad_out),
        .ad_oe  (ad_oe),
        .cs_n   (cs_n),
        .ad_sel (ad_sel),
        .wr_n   (wr_n),
        .rd_n   (rd_n),
        .rdata  (rdata),
        .busy   (busy),
        .done   (done)
    );

    rtc_bus_cycle #(
        .T_STROBE (1),
        .T_HOLD   (1),
        .T_GAP    (1)
    ) fast (
        .clk    (clk),
        .rst    (rst),
        .start  (f_start),
        .wr_rd  (f_wr_rd),
        .addr   (f_addr),
        .wdata  (f_wdata),
        .ad_in  (f_ad_in),
        .ad_out (f_ad_out),
        .ad_oe  (f_ad_oe),
        .cs_n   (f_cs_n),
        .ad_sel (f_ad_sel),
        .wr_n   (f_wr_n),
        .rd_n   (f_rd_n),
        .rdata  (f_rdata),
        .busy   (f_busy),
        .done   (f_done)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Strobe exclusivity and no-drive-while-reading, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_main",
                32'(!(!wr_n && !rd_n) &&
                    !((!wr_n || !rd_n) && cs_n) &&
                    !(!rd_n && ad_oe)), 32'd1);
            chk("mon_fast",
                32'(!(!f_wr_n && !f_rd_n) &&
                    !((!f_wr_n || !f_rd_n) && f_cs_n) &&
                    !(!f_rd_n && f_ad_oe)), 32'd1);
        end
    end

    // One full transaction on the default-timing instance,
    // checked phase by phase.
    task automatic xfer(
        input logic       wr,
        input logic [7:0] a,
        input logic [7:0] d,
        input logic [7:0] rin
    );
        wr_rd = wr;
        addr  = a;
        wdata = d;
        ad_in = ~rin;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        repeat (4) begin
            chk("a_stb", {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out},
                {5'b00101, a});
            tick();
        end
        repeat (2) begin
            chk("a_hld", {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out},
                {5'b11101, a});
            tick();
        end
        repeat (2) begin
            chk("gap", {cs_n, wr_n, rd_n, ad_oe, ad_out},
                {4'b1110, 8'h00});
            tick();
        end
        ad_in = rin;
        repeat (4) begin
            if (wr)
                chk("d_stb_wr",
                    {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out},
                    {5'b00111, d});
            else
                chk("d_stb_rd", {cs_n, wr_n, rd_n, ad_sel, ad_oe},
                    5'b01010);
            chk("d_stb_rdata", 32'(rdata), 32'(m_rdata));
            tick();
        end
        ad_in = ~rin;
        if (!wr) m_rdata = rin;
        repeat (2) begin
            if (wr)
                chk("d_hld_wr",
                    {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out},
                    {5'b11111, d});
            else
                chk("d_hld_rd", {cs_n, wr_n, rd_n, ad_sel, ad_oe},
                    5'b11110);
            chk("d_hld_done", 32'(done), 32'd0);
            tick();
        end
        chk("fin", {done, busy, cs_n, wr_n, rd_n}, 5'b11111);
        chk("fin_rdata", 32'(rdata), 32'(m_rdata));
        tick();
        chk("post_fin", {done, busy}, 2'b00);
    endtask

    initial begin
        int n_done;
        int first_at;
        int second_at;

        #12;
        chk("rst_main",
            {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out, rdata, busy, done},
            {5'b11100, 8'h00, 8'h00, 2'b00});
        chk("rst_fast",
            {f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_ad_oe, f_ad_out,
             f_rdata, f_busy, f_done},
            {5'b11100, 8'h00, 8'h00, 2'b00});
        rst = 1'b0;
        tick();

        xfer(1'b1, 8'h21, 8'h45, 8'h00);
        xfer(1'b0, 8'h24, 8'h00, 8'h59);
        xfer(1'b0, 8'h24, 8'h00, 8'h00);

        // Abort a read in the middle of its data strobe.
        wr_rd = 1'b0;
        addr  = 8'h24;
        ad_in = 8'h77;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("pre_rst", {cs_n, rd_n, ad_sel}, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async",
            {cs_n, wr_n, rd_n, ad_sel, ad_oe, ad_out, rdata, busy, done},
            {5'b11100, 8'h00, m_rdata, 2'b00});
        tick();
        tick();
        rst = 1'b0;
        n_done = 0;
        repeat (20) begin
            tick();
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'(m_rdata));
        xfer(1'b1, 8'h33, 8'h99, 8'h00);

        // start held high: only two cycles fit in 30 edges.
        wr_rd     = 1'b1;
        addr      = 8'h10;
        wdata     = 8'h5A;
        start     = 1'b1;
        n_done    = 0;
        first_at  = -1;
        second_at = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (i == 29) start = 1'b0;
            if (done) begin
                n_done++;
                if (first_at < 0) first_at = i;
                else if (second_at < 0) second_at = i;
            end
        end
        chk("hold_count", 32'(n_done), 32'd2);
        chk("hold_first", 32'(first_at), 32'd14);
        chk("hold_period", 32'(second_at - first_at), 32'd16);

        // Short-timing instance: one cycle per phase.
        f_wr_rd = 1'b1;
        f_addr  = 8'h5A;
        f_wdata = 8'hC3;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        chk("f_a_stb",
            {f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_ad_oe, f_ad_out},
            {5'b00101, 8'h5A});
        tick();
        chk("f_a_hld",
            {f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_ad_oe, f_ad_out},
            {5'b11101, 8'h5A});
        tick();
        chk("f_gap", {f_cs_n, f_wr_n, f_rd_n, f_ad_oe, f_ad_out},
            {4'b1110, 8'h00});
        tick();
        chk("f_d_stb",
            {f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_ad_oe, f_ad_out},
            {5'b00111, 8'hC3});
        tick();
        chk("f_d_hld",
            {f_cs_n, f_wr_n, f_rd_n, f_ad_sel, f_ad_oe, f_ad_out,
             f_done},
            {5'b11111, 8'hC3, 1'b0});
        tick();
        chk("f_done", {f_done, f_busy}, 2'b11);
        tick();
        chk("f_idle", {f_done, f_busy}, 2'b00);

        f_wr_rd = 1'b0;
        f_ad_in = 8'hA7;
        f_start = 1'b1;
        tick();
        f_start = 1'b0;
        repeat (3) tick();
        chk("f_rd_stb", {f_cs_n, f_rd_n, f_ad_oe}, 3'b000);
        tick();
        f_ad_in = 8'h00;
        tick();
        chk("f_rd_done", {f_done, f_rdata}, {1'b1, 8'hA7});

        // Random traffic under the strobe monitor.
        for (int i = 0; i < 8; i++) begin
            xfer(1'($urandom_range(0, 1)), 8'($urandom),
                 8'($urandom), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
